seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_pkg.sv | 29 ++
 rtl/seg_slot_timer.sv | 53 +++++
 rtl/seg_scan_driver.sv | 106 ++++++++++
 tb/tb_seg_scan_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan driver.
// Holds FSM encodings, digit count and inactive-level helpers.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIG_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    function automatic logic [7:0] an_idle(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] seg_idle(input bit invert);
        return invert ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] an_sel(input logic [DIG_W-1:0] d,
                                          input bit active_low);
        logic [7:0] oh;
        oh = 8'b1 << d;
        return active_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter and digit index for the scan driver.
// Exposes look-ahead values so the top can register its outputs.
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1000,
    parameter int          CNT_W   = $clog2(CLK_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [DIG_W-1:0] dig_o,
    output logic             slot_end_o,
    output logic             frame_end_o
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0] dig_q, dig_d;

    assign slot_end_o  = (cnt_q == LAST);
    assign frame_end_o = slot_end_o && (dig_q == LAST_DIG);
    assign cnt_o       = cnt_d;
    assign dig_o       = dig_d;

    // Anything other than advancing restarts the scan at digit 0.
    always_comb begin
        cnt_d = '0;
        dig_d = '0;
        if (adv_i) begin
            if (slot_end_o) begin
                dig_d = dig_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                dig_d = dig_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with
// per-frame snapshot of the segment patterns and blanking per slot.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 1000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter bit          AN_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_INVERT    = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scan_en_i,
    input  logic [7:0] seg_in_0_i,
    input  logic [7:0] seg_in_1_i,
    input  logic [7:0] seg_in_2_i,
    input  logic [7:0] seg_in_3_i,
    input  logic [7:0] seg_in_4_i,
    input  logic [7:0] seg_in_5_i,
    input  logic [7:0] seg_in_6_i,
    input  logic [7:0] seg_in_7_i,
    output logic [7:0] seg_an_o,
    output logic [7:0] seg_cathode_o,
    output logic       frame_done_o,
    output logic       busy_o
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W:0]   BLK      = (CNT_W + 1)'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       AN_OFF   = an_idle(AN_ACTIVE_LOW);
    localparam logic [7:0]       SEG_OFF  = seg_idle(SEG_INVERT);

    state_e state_q, state_d;
    logic [7:0][7:0] snap_q, snap_d, seg_in;
    logic [7:0] an_q, an_d, cath_q, cath_d;
    logic done_q, done_d, busy_q, busy_d;

    logic             adv, slot_end, frame_end, in_blank;
    logic [CNT_W-1:0] cnt_nxt;
    logic [DIG_W-1:0] dig_nxt;

    assign seg_in = {seg_in_7_i, seg_in_6_i, seg_in_5_i, seg_in_4_i,
                     seg_in_3_i, seg_in_2_i, seg_in_1_i, seg_in_0_i};
    assign adv = (state_q != ST_IDLE) && scan_en_i;

    seg_slot_timer #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .adv_i       (adv),
        .cnt_o       (cnt_nxt),
        .dig_o       (dig_nxt),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

    // Outputs are decoded from next-state so they line up with the state.
    assign in_blank = (({1'b0, cnt_nxt} + 1'b1) <= BLK);

    always_comb begin
        state_d = ST_IDLE;
        snap_d  = snap_q;
        if (scan_en_i) begin
            state_d = in_blank ? ST_BLANK : ST_SHOW;
            if (state_q == ST_IDLE || frame_end) begin
                snap_d = seg_in;
            end
        end
        an_d   = AN_OFF;
        cath_d = SEG_OFF;
        if (state_d == ST_SHOW) begin
            an_d   = an_sel(dig_nxt, AN_ACTIVE_LOW);
            cath_d = snap_d[dig_nxt] ^ {8{SEG_INVERT}};
        end
        busy_d = (state_d != ST_IDLE);
        done_d = busy_d && (cnt_nxt == LAST) && (dig_nxt == LAST_DIG);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            an_q    <= AN_OFF;
            cath_q  <= SEG_OFF;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            cath_q  <= cath_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign seg_an_o      = an_q;
    assign seg_cathode_o = cath_q;
    assign frame_done_o  = done_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: CLK_DIV=8, BLANK_CYCLES=2 instance
// plus a BLANK_CYCLES=0, SEG_INVERT=1 instance.
module tb_seg_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en0, en1;
    logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic [7:0] an0, cat0, an1, cat1;
    logic done0, busy0, done1, busy1;

    int n_chk = 0;
    int n_fail = 0;

    seg_scan_driver #(
        .CLK_DIV(8), .BLANK_CYCLES(2),
        .AN_ACTIVE_LOW(1'b1), .SEG_INVERT(1'b0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .scan_en_i(en0),
        .seg_in_0_i(s0), .seg_in_1_i(s1), .seg_in_2_i(s2), .seg_in_3_i(s3),
        .seg_in_4_i(s4), .seg_in_5_i(s5), .seg_in_6_i(s6), .seg_in_7_i(s7),
        .seg_an_o(an0), .seg_cathode_o(cat0),
        .frame_done_o(done0), .busy_o(busy0)
    );

    seg_scan_driver #(
        .CLK_DIV(8), .BLANK_CYCLES(0),
        .AN_ACTIVE_LOW(1'b1), .SEG_INVERT(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .scan_en_i(en1),
        .seg_in_0_i(s0), .seg_in_1_i(s1), .seg_in_2_i(s2), .seg_in_3_i(s3),
        .seg_in_4_i(s4), .seg_in_5_i(s5), .seg_in_6_i(s6), .seg_in_7_i(s7),
        .seg_an_o(an1), .seg_cathode_o(cat1),
        .frame_done_o(done1), .busy_o(busy1)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk0(input string nm, input logic [7:0] an,
                        input logic [7:0] cat, input logic done,
                        input logic busy);
        chk({nm, "_an"}, an0, an);
        chk({nm, "_cat"}, cat0, cat);
        chk({nm, "_done"}, {7'd0, done0}, {7'd0, done});
        chk({nm, "_busy"}, {7'd0, busy0}, {7'd0, busy});
    endtask

    task automatic chk1(input string nm, input logic [7:0] an,
                        input logic [7:0] cat, input logic done,
                        input logic busy);
        chk({nm, "_an"}, an1, an);
        chk({nm, "_cat"}, cat1, cat);
        chk({nm, "_done"}, {7'd0, done1}, {7'd0, done});
        chk({nm, "_busy"}, {7'd0, busy1}, {7'd0, busy});
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] cat;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int ndone;
        tbl[0]  = '{1,   8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{2,   8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[2]  = '{3,   8'hFE, 8'h3F, 1'b0, 1'b1};
        tbl[3]  = '{8,   8'hFE, 8'h3F, 1'b0, 1'b1};
        tbl[4]  = '{9,   8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[5]  = '{10,  8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{11,  8'hFD, 8'h06, 1'b0, 1'b1};
        tbl[7]  = '{16,  8'hFD, 8'h06, 1'b0, 1'b1};
        tbl[8]  = '{17,  8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{19,  8'hFB, 8'h5B, 1'b0, 1'b1};
        tbl[10] = '{27,  8'hF7, 8'h4F, 1'b0, 1'b1};
        tbl[11] = '{59,  8'h7F, 8'h07, 1'b0, 1'b1};
        tbl[12] = '{63,  8'h7F, 8'h07, 1'b0, 1'b1};
        tbl[13] = '{64,  8'h7F, 8'h07, 1'b1, 1'b1};
        tbl[14] = '{65,  8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[15] = '{67,  8'hFE, 8'h5B, 1'b0, 1'b1};
        tbl[16] = '{128, 8'h7F, 8'h07, 1'b1, 1'b1};

        rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
        s0 = 8'h3F; s1 = 8'h06; s2 = 8'h5B; s3 = 8'h4F;
        s4 = 8'h66; s5 = 8'h6D; s6 = 8'h7D; s7 = 8'h07;

        repeat (2) @(negedge clk);
        chk0("rst0", 8'hFF, 8'h00, 1'b0, 1'b0);
        chk1("rst1", 8'hFF, 8'hFF, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk0("idle0", 8'hFF, 8'h00, 1'b0, 1'b0);
        en0 = 1'b1;

        // Two gapless frames; seg_in_0 changes mid-frame at cycle 5.
        ndone = 0;
        for (int cyc = 1; cyc <= 128; cyc++) begin
            @(negedge clk);
            foreach (tbl[i]) begin
                if (tbl[i].cyc == cyc)
                    chk0($sformatf("v%0d", cyc), tbl[i].an, tbl[i].cat,
                         tbl[i].done, tbl[i].busy);
            end
            if ($countones(~an0) > 1)
                chk($sformatf("onehot%0d", cyc), an0, 8'hFF);
            if (done0) ndone++;
            if (cyc == 5) s0 = 8'h5B;
        end
        chk("done_cnt", 8'(ndone), 8'd2);

        // Drop scan_en during digit 3 SHOW of the third frame.
        repeat (29) @(negedge clk);
        chk0("d3show", 8'hF7, 8'h4F, 1'b0, 1'b1);
        en0 = 1'b0;
        @(negedge clk);
        chk0("drop", 8'hFF, 8'h00, 1'b0, 1'b0);
        en0 = 1'b1;
        @(negedge clk);
        chk0("re_b1", 8'hFF, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk0("re_b2", 8'hFF, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk0("re_s", 8'hFE, 8'h5B, 1'b0, 1'b1);

        // Drop scan_en on the frame_done cycle.
        repeat (61) @(negedge clk);
        chk0("fd_last", 8'h7F, 8'h07, 1'b1, 1'b1);
        en0 = 1'b0;
        @(negedge clk);
        chk0("fd_idle", 8'hFF, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a SHOW cycle.
        en0 = 1'b1;
        repeat (3) @(negedge clk);
        chk0("pre_rst", 8'hFE, 8'h5B, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 chk0("async_rst", 8'hFF, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk0("in_rst", 8'hFF, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk0("post_b", 8'hFF, 8'h00, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk0("post_s", 8'hFE, 8'h5B, 1'b0, 1'b1);
        en0 = 1'b0;
        @(negedge clk);

        // No-blank, inverted-segment instance.
        chk1("inv_idle", 8'hFF, 8'hFF, 1'b0, 1'b0);
        en1 = 1'b1;
        @(negedge clk);
        chk1("inv_c1", 8'hFE, 8'hA4, 1'b0, 1'b1);
        repeat (7) @(negedge clk);
        chk1("inv_c8", 8'hFE, 8'hA4, 1'b0, 1'b1);
        @(negedge clk);
        chk1("inv_c9", 8'hFD, 8'hF9, 1'b0, 1'b1);
        repeat (55) @(negedge clk);
        chk1("inv_c64", 8'h7F, 8'hF8, 1'b1, 1'b1);
        @(negedge clk);
        chk1("inv_c65", 8'hFE, 8'hA4, 1'b0, 1'b1);
        chk0("dut0_dark", 8'hFF, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
